// File: rtl/reg_file_sb.sv
// Integer register file with NUM_RD combinational read ports, one write port and a
// per-register busy scoreboard for RAW hazard detection. Define REG_FILE_SB_BYPASS_EN to forward write data to reads.
module reg_file_sb #(
  parameter int ADDR_WDTH = 5,
  parameter int DATA_WDTH = 32,
  parameter int NUM_RD    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_RD*ADDR_WDTH-1:0]   rd_ad_i,
  output logic [NUM_RD*DATA_WDTH-1:0]   rd_o,
  output logic [NUM_RD-1:0]             rd_busy_o,
  input  logic                          we_i,
  input  logic [ADDR_WDTH-1:0]          wr_ad_i,
  input  logic [DATA_WDTH-1:0]          wr_d_i,
  input  logic                          rsv_i,
  input  logic [ADDR_WDTH-1:0]          rsv_ad_i,
  input  logic                          flush_i,
  output logic [ADDR_WDTH:0]            busy_cnt_o,
  output logic                          any_busy_o
);

  localparam int DEPTH = 2 ** ADDR_WDTH;

  logic [DATA_WDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]     busy_q;
  logic [DEPTH-1:0]     busy_d;
  logic [ADDR_WDTH:0]   cnt_q;
  logic [ADDR_WDTH:0]   cnt_d;
  logic                 wr_ok;
  logic                 rsv_ok;

  assign wr_ok  = we_i && (wr_ad_i != '0);
  assign rsv_ok = rsv_i && (rsv_ad_i != '0);

  // Later assignments win: flush over reserve over write-retire.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)   busy_d[wr_ad_i]  = 1'b0;
    if (rsv_ok)  busy_d[rsv_ad_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_WDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_ad_i] <= wr_d_i;
    end
  end

  assign busy_cnt_o = cnt_q;
  assign any_busy_o = (cnt_q != '0);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WDTH-1:0] ra;
    logic [DATA_WDTH-1:0] rdata;
    logic                 rbusy;

    assign ra = rd_ad_i[k*ADDR_WDTH +: ADDR_WDTH];

    always_comb begin
      rdata = (ra == '0) ? '0 : regs_q[ra];
      rbusy = busy_q[ra];
`ifdef REG_FILE_SB_BYPASS_EN
      // A retiring write frees the register unless it is re-reserved this same cycle.
      if (wr_ok && (wr_ad_i == ra)) begin
        rdata = wr_d_i;
        rbusy = rsv_i && (rsv_ad_i == ra);
      end
`endif
    end

    assign rd_o[k*DATA_WDTH +: DATA_WDTH] = rdata;
    assign rd_busy_o[k]                   = rbusy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb (3 read ports): directed scenarios plus random traffic
// compared against an array-based reference model of the register file and scoreboard.
module tb_reg_file_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int DEPTH = 32;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_ad;
  logic [NR*DW-1:0]  rd_o;
  logic [NR-1:0]     rd_busy;
  logic              we;
  logic [AW-1:0]     wr_ad;
  logic [DW-1:0]     wr_d;
  logic              rsv;
  logic [AW-1:0]     rsv_ad;
  logic              flush;
  logic [AW:0]       busy_cnt;
  logic              any_busy;

  reg_file_sb #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .NUM_RD(NR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_ad_i(rd_ad), .rd_o(rd_o), .rd_busy_o(rd_busy),
    .we_i(we), .wr_ad_i(wr_ad), .wr_d_i(wr_d), .rsv_i(rsv), .rsv_ad_i(rsv_ad),
    .flush_i(flush), .busy_cnt_o(busy_cnt), .any_busy_o(any_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (we && wr_ad == a) return wr_d;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (we && wr_ad == a) return rsv && rsv_ad == a;
`endif
    return m_busy[a];
  endfunction

  // Applied at the edge with the inputs that were present before it.
  function automatic void model_edge();
    if (we && wr_ad != 0) begin
      m_regs[wr_ad] = wr_d;
      m_busy[wr_ad] = 0;
    end
    if (rsv && rsv_ad != 0) m_busy[rsv_ad] = 1;
    if (flush) for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      a = rd_ad[k*AW +: AW];
      check($sformatf("rd%0d(x%0d)", k, a), rd_o[k*DW +: DW], exp_rd(a));
      check($sformatf("busy%0d(x%0d)", k, a), rd_busy[k], exp_busy(a));
    end
    check("busy_cnt", busy_cnt, model_cnt());
    check("any_busy", any_busy, model_cnt() != 0);
  endtask

  // driver tasks; all start and end at posedge + 1
  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_ad = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    we = 0; wr_ad = '0; wr_d = '0; rsv = 0; rsv_ad = '0; flush = 0;
  endtask

  task automatic do_cycle(input bit w, input int wa, input logic [DW-1:0] wd,
                          input bit r, input int ra, input bit fl);
    we = w; wr_ad = AW'(wa); wr_d = wd; rsv = r; rsv_ad = AW'(ra); flush = fl;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    idle();
  endtask

  logic [NR*DW-1:0] exp_wide;

  initial begin
    rst_n = 0;
    idle();
    set_rd(0, 0, 0);
    model_reset();
    #3;
    check("reset_cnt", busy_cnt, 0);
    check("reset_any", any_busy, 0);
    check("reset_rd", rd_o, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // x0 is hard-wired
    do_cycle(1, 0, 32'hDEADBEEF, 0, 0, 0);
    set_rd(0, 0, 0);
    #1;
    check("x0_read", rd_o[DW-1:0], 0);
    check("x0_cnt", busy_cnt, 0);

    // reserve then retire x5
    do_cycle(0, 0, 0, 1, 5, 0);
    set_rd(5, 0, 0);
    #1;
    check("x5_busy", rd_busy[0], 1);
    check("x5_cnt", busy_cnt, 1);
    do_cycle(1, 5, 32'h12345678, 0, 0, 0);
    #1;
    check("x5_free", rd_busy[0], 0);
    check("x5_cnt0", busy_cnt, 0);
    check("x5_data", rd_o[DW-1:0], 32'h12345678);

    // simultaneous reserve and write of x7
    do_cycle(0, 0, 0, 1, 7, 0);
    do_cycle(1, 7, 32'h77, 1, 7, 0);
    set_rd(7, 8, 0);
    #1;
    check("x7_data", rd_o[DW-1:0], 32'h77);
    check("x7_busy", rd_busy[0], 1);
    check("x7_cnt", busy_cnt, 1);
    do_cycle(1, 7, 32'h78, 1, 8, 0);
    #1;
    check("x7x8_cnt", busy_cnt, 1);
    check("x7x8_busy", rd_busy[1:0], 2'b10);

    // flush drops reservation but commits write
    do_cycle(0, 0, 0, 0, 0, 1);
    do_cycle(0, 0, 0, 1, 1, 0);
    do_cycle(0, 0, 0, 1, 2, 0);
    do_cycle(0, 0, 0, 1, 3, 0);
    #1;
    check("pre_flush_cnt", busy_cnt, 3);
    do_cycle(1, 1, 32'hA5, 1, 4, 1);
    set_rd(1, 4, 2);
    #1;
    check("flush_cnt", busy_cnt, 0);
    check("flush_any", any_busy, 0);
    check("flush_busy", rd_busy, 3'b000);
    check("flush_x1", rd_o[DW-1:0], 32'hA5);

    // same-cycle read of x9 during its write
    set_rd(9, 0, 0);
    we = 1; wr_ad = 9; wr_d = 32'hCAFE0001;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    check("x9_same_cycle", rd_o[DW-1:0], 32'hCAFE0001);
`else
    check("x9_same_cycle", rd_o[DW-1:0], 32'h0);
`endif
    @(posedge clk);
    model_edge();
    #1;
    idle();
    check("x9_next_cycle", rd_o[DW-1:0], 32'hCAFE0001);

    // three ports
    do_cycle(1, 1, 11, 0, 0, 0);
    do_cycle(1, 2, 22, 0, 0, 0);
    set_rd(1, 2, 0);
    #1;
    exp_wide = {32'd0, 32'd22, 32'd11};
    check("multi_rd", rd_o, exp_wide);
    do_cycle(0, 0, 0, 1, 2, 0);
    #1;
    check("multi_busy", rd_busy, 3'b010);

    // reset mid-operation with pending reserve and write
    do_cycle(0, 0, 0, 1, 6, 0);
    set_rd(1, 2, 6);
    we = 1; wr_ad = 11; wr_d = 32'h1111; rsv = 1; rsv_ad = 10;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("async_rd", rd_o, 0);
    check("async_busy", rd_busy, 0);
    check("async_cnt", busy_cnt, 0);
    check("async_any", any_busy, 0);
    @(posedge clk);
    #1;
    check("held_cnt", busy_cnt, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // random traffic
    for (int n = 0; n < 500; n++) begin
      int wa, ra, a0;
      wa = (n % 4 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 12);
      ra = $urandom_range(0, 12);
      a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      set_rd(a0, $urandom_range(0, 12), $urandom_range(0, 31));
      do_cycle($urandom_range(0, 1) == 1, wa, $urandom, $urandom_range(0, 1) == 1, ra,
               $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file with NUM_RD asynchronous read ports and one synchronous write port.
- Per-register scoreboard ("busy" bits) tracks in-flight writes so the issue stage can detect RAW hazards and stall.
- Keeps an outstanding-write counter.
- Sits between decode/issue and writeback; register 0 is hard-wired to zero.

Parameters:
- ADDR_WDTH, 5, register address width; depth = 2**ADDR_WDTH.
- DATA_WDTH, 32, register data width.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- rd_ad_i  input  NUM_RD*ADDR_WDTH  packed read addresses; port k at bits [k*ADDR_WDTH +: ADDR_WDTH].
- rd_o  output  NUM_RD*DATA_WDTH  packed read data; port k at bits [k*DATA_WDTH +: DATA_WDTH].
- rd_busy_o  output  NUM_RD  bit k = scoreboard busy bit of rd_ad_i port k.
- we_i  input  1  writeback enable.
- wr_ad_i  input  ADDR_WDTH  writeback address.
- wr_d_i  input  DATA_WDTH  writeback data.
- rsv_i  input  1  reserve destination (instruction issued).
- rsv_ad_i  input  ADDR_WDTH  destination address to mark busy.
- flush_i  input  1  clear all busy bits (pipeline flush).
- busy_cnt_o  output  ADDR_WDTH+1  number of registers currently busy.
- any_busy_o  output  1  busy_cnt_o != 0.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. Reset clears:
  - all registers to 0;
  - all busy bits to 0;
  - busy_cnt_o to 0.
  - Outputs during and after reset: rd_o = 0, rd_busy_o = 0, any_busy_o = 0.
  - Reset asserted mid-operation discards every pending reservation and write immediately (no clock needed).
- Reads: combinational, zero latency. rd_o port k = reg[rd_ad_i k], or 0 when rd_ad_i k == 0. rd_busy_o is also combinational from the current busy state.
- Write: when we_i=1 and wr_ad_i!=0, reg[wr_ad_i] <= wr_d_i at the edge, and busy[wr_ad_i] is cleared (subject to priority below). Writes to address 0 are ignored.
- Reserve: when rsv_i=1 and rsv_ad_i!=0, busy[rsv_ad_i] <= 1 at the edge. Reservations of address 0 are ignored.
- Priority per busy bit, evaluated at each edge, highest first:
  1. flush_i=1: all busy bits <= 0. A reservation in the same cycle is dropped; a write in the same cycle still commits data.
  2. rsv to address A: busy[A] <= 1, even if we_i writes A in the same cycle (the new reservation supersedes the retiring one; data is still written).
  3. we to address A: busy[A] <= 0.
  4. Otherwise the bit holds.
- Redundant operations:
  - Reserving an already-busy register leaves it busy; no counting of multiple outstanding writes per register.
  - Writing a non-busy register is legal: data is written, busy stays 0.
- busy_cnt_o: registered; always equals the population count of the busy bits after the edge. It changes by:
  - +1 for rsv to a non-busy register;
  - -1 for we to a busy register without rsv to the same address;
  - 0 when rsv and we are to different addresses and both change state (one +1, one -1);
  - to 0 on flush.
  - Maximum value is 2**ADDR_WDTH-1.
- Same-cycle read of the address being written: returns the old value unless BYPASS_EN is defined. rd_busy_o reflects pre-edge state.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined: for each read port k, if we_i=1, wr_ad_i==rd_ad_i k and the address !=0, then:
  - rd_o port k = wr_d_i combinationally in the same cycle;
  - rd_busy_o bit k = 0 unless rsv_i=1 targets the same address.
- Undefined: no forwarding; the read returns the stored value until the edge after the write.

Test Plan:
- Reset and x0:
  - Stimulus: assert rst_ni=0 asynchronously between edges.
  - Required: rd_o=0, busy_cnt_o=0, any_busy_o=0 immediately.
  - Stimulus: then write 0xDEADBEEF to x0, read port 0 at address 0.
  - Required: reads 0, busy_cnt_o stays 0.
- Reserve then write x5:
  - Stimulus: rsv x5.
  - Required: next cycle rd_busy_o[0]=1 with rd_ad_i port0=5, busy_cnt_o=1.
  - Stimulus: we x5=0x12345678.
  - Required: next cycle busy=0, busy_cnt_o=0, rd_o port0=0x12345678.
- Simultaneous rsv and we to x7 (x7 busy, count=1):
  - Required: after the edge x7 holds the new data, busy[7]=1, busy_cnt_o=1.
  - Stimulus: rsv x8 and we x7 in the same cycle.
  - Required: count stays 1 (x8 busy, x7 free).
- Flush:
  - Stimulus: reserve x1, x2, x3 (count=3), then flush_i=1 with rsv x4 and we x1=0xA5.
  - Required: count=0, no busy bits, x1=0xA5.
- Bypass, same-cycle read of x9 during write 0xCAFE0001 (old value 0):
  - With REG_FILE_SB_BYPASS_EN: rd_o=0xCAFE0001 in that cycle.
  - Without it: rd_o=0, then 0xCAFE0001 the next cycle.
- Multi-port, NUM_RD=3: read x1, x2, x0 with x1=11 and x2=22.
  - Required: rd_o ports = {0, 22, 11} (ports 2, 1, 0).
  - Stimulus: x2 busy.
  - Required: rd_busy_o=3'b010.
